polyphase_coeff_bank_ctrl: RTL and testbench

//  Sequences the polyphase filter's double-banked, single-port coefficient RAM (2 x 512 x 32).

---
 rtl/polyphase_coeff_bank_ctrl_if.sv | 25 ++
 rtl/polyphase_coeff_bank_ctrl.sv | 110 +++++++++++
 tb/tb_polyphase_coeff_bank_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/polyphase_coeff_bank_ctrl_if.sv
// Host-side port bundle for the coefficient bank controller: register-bus writes
// plus the datapath read request/response handshake.
interface polyphase_coeff_bank_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_wen;
    logic                dp_req_valid;
    logic                dp_req_ready;
    logic [ADDR_W-1:0]   dp_req_addr;
    logic                dp_rsp_valid;
    logic [DATA_W-1:0]   dp_rsp_data;

    modport master (
        output bus_addr, bus_wdata, bus_wen, dp_req_valid, dp_req_addr,
        input  dp_req_ready, dp_rsp_valid, dp_rsp_data
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wen, dp_req_valid, dp_req_addr,
        output dp_req_ready, dp_rsp_valid, dp_rsp_data
    );
endinterface

// File: rtl/polyphase_coeff_bank_ctrl.sv
// Arbitrates the single-port double-banked coefficient RAM between register-bus
// writes (shadow bank, never stalled) and datapath reads (active bank), and swaps banks on frame boundaries.
module polyphase_coeff_bank_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_STALL = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    polyphase_coeff_bank_ctrl_if.slave   io_host,
    input  logic                         i_swap_req,
    input  logic                         i_dp_frame_end,
    output logic                         o_ram_en,
    output logic [DATA_W/8-1:0]          o_ram_we,
    output logic [ADDR_W:0]              o_ram_addr,
    output logic [DATA_W-1:0]            o_ram_wdata,
    input  logic [DATA_W-1:0]            i_ram_rdata,
    output logic                         o_active_bank,
    output logic                         o_swap_pending,
    output logic                         o_stall_err
);
    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_active_bank;
    logic             w_bank_nxt;
    logic             r_dp_rsp_vld_p1;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic             r_stall_err;
    logic             w_bus_wr;
    logic             w_dp_acc;
    logic             w_dp_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == STALL_MAX) ? cnt : cnt + 1'b1;
    endfunction

    assign w_bus_wr   = |io_host.bus_wen;
    assign w_dp_acc   = io_host.dp_req_valid & ~w_bus_wr;
    assign w_dp_stall = io_host.dp_req_valid & w_bus_wr;

    // Bus writes always win the RAM port since the register bus cannot be back-pressured.
    always_comb begin
        o_ram_en             = 1'b0;
        o_ram_we             = '0;
        o_ram_addr           = {r_active_bank, io_host.dp_req_addr};
        o_ram_wdata          = io_host.bus_wdata;
        io_host.dp_req_ready = 1'b0;
        if (w_bus_wr) begin
            o_ram_en   = 1'b1;
            o_ram_we   = io_host.bus_wen;
            o_ram_addr = {~r_active_bank, io_host.bus_addr};
        end else if (io_host.dp_req_valid) begin
            o_ram_en             = 1'b1;
            io_host.dp_req_ready = 1'b1;
        end
    end

    // Bank toggles on the registered edge, so frame_end-cycle accesses still see the old banks.
    always_comb begin
        w_state_nxt = r_state;
        w_bank_nxt  = r_active_bank;
        case (r_state)
            ST_RUN: begin
                if (i_swap_req) w_state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (i_dp_frame_end) begin
                    w_state_nxt = ST_RUN;
                    w_bank_nxt  = ~r_active_bank;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_stall_cnt_nxt = w_dp_stall ? sat_inc(r_stall_cnt) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_RUN;
            r_active_bank   <= 1'b0;
            r_dp_rsp_vld_p1 <= 1'b0;
            r_stall_cnt     <= '0;
            r_stall_err     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_active_bank   <= w_bank_nxt;
            r_dp_rsp_vld_p1 <= w_dp_acc;
            r_stall_cnt     <= w_stall_cnt_nxt;
            if (w_stall_cnt_nxt == STALL_MAX) r_stall_err <= 1'b1;
        end
    end

    // p1: RAM returns read data one cycle after the accepted request.
    assign io_host.dp_rsp_valid = r_dp_rsp_vld_p1;
    assign io_host.dp_rsp_data  = i_ram_rdata;

    assign o_active_bank  = r_active_bank;
    assign o_swap_pending = (r_state == ST_PENDING);
    assign o_stall_err    = r_stall_err;
endmodule

// File: tb/tb_polyphase_coeff_bank_ctrl.sv
// Randomized self-checking bench: a behavioural RAM and bank-swap model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_polyphase_coeff_bank_ctrl;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int MAX_STALL = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        swap_req  = 1'b0;
    logic        frame_end = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        active_bank;
    logic        swap_pending;
    logic        stall_err;

    always #5 clk = ~clk;

    polyphase_coeff_bank_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

    polyphase_coeff_bank_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STALL(MAX_STALL)) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .io_host        (u_if),
        .i_swap_req     (swap_req),
        .i_dp_frame_end (frame_end),
        .o_ram_en       (ram_en),
        .o_ram_we       (ram_we),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .i_ram_rdata    (ram_rdata),
        .o_active_bank  (active_bank),
        .o_swap_pending (swap_pending),
        .o_stall_err    (stall_err)
    );

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    bit          m_bank, m_pend, m_err, m_rsp_vld;
    int          m_cnt;
    logic [31:0] m_rsp_data;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
    end

    // Single-port RAM environment, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        logic bw;
        logic acc;
        if (!rst_n) begin
            m_bank = 0; m_pend = 0; m_err = 0; m_rsp_vld = 0; m_cnt = 0;
        end
        bw  = (u_if.bus_wen != 4'h0);
        acc = u_if.dp_req_valid && !bw;
        chk("m_ram_en", ram_en, bw || u_if.dp_req_valid);
        chk("m_ram_we", ram_we, bw ? u_if.bus_wen : 4'h0);
        chk("m_ready", u_if.dp_req_ready, acc);
        if (bw) begin
            chk("m_waddr", ram_addr, {~m_bank, u_if.bus_addr});
            chk("m_wdata", ram_wdata, u_if.bus_wdata);
        end else if (acc) begin
            chk("m_raddr", ram_addr, {m_bank, u_if.dp_req_addr});
        end
        chk("m_bank", active_bank, m_bank);
        chk("m_pending", swap_pending, m_pend);
        chk("m_stall_err", stall_err, m_err);
        chk("m_rsp_valid", u_if.dp_rsp_valid, m_rsp_vld);
        if (m_rsp_vld) chk("m_rsp_data", u_if.dp_rsp_data, m_rsp_data);

        if (rst_n) begin
            if (bw)
                for (int b = 0; b < 4; b++)
                    if (u_if.bus_wen[b])
                        ref_mem[{~m_bank, u_if.bus_addr}][b*8 +: 8] = u_if.bus_wdata[b*8 +: 8];
            m_rsp_vld = acc;
            if (acc) m_rsp_data = ref_mem[{m_bank, u_if.dp_req_addr}];
            if (u_if.dp_req_valid && bw) m_cnt = (m_cnt < MAX_STALL) ? m_cnt + 1 : m_cnt;
            else m_cnt = 0;
            if (m_cnt >= MAX_STALL) m_err = 1;
            if (m_pend) begin
                if (frame_end) begin m_bank = ~m_bank; m_pend = 0; end
            end else if (swap_req) begin
                m_pend = 1;
            end
        end
    end

    task automatic drv(input logic [3:0] wen, input logic [8:0] ba, input logic [31:0] wd,
                       input logic dv, input logic [8:0] da, input logic sw, input logic fe);
        @(posedge clk);
        #1;
        u_if.bus_wen      = wen;
        u_if.bus_addr     = ba;
        u_if.bus_wdata    = wd;
        u_if.dp_req_valid = dv;
        u_if.dp_req_addr  = da;
        swap_req          = sw;
        frame_end         = fe;
    endtask

    task automatic idle();
        drv(4'h0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int burst;
        u_if.bus_wen = 4'h0; u_if.bus_addr = '0; u_if.bus_wdata = '0;
        u_if.dp_req_valid = 1'b0; u_if.dp_req_addr = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bank", active_bank, 1'b0);
        chk("rst_pending", swap_pending, 1'b0);
        chk("rst_stall_err", stall_err, 1'b0);
        chk("rst_rsp_valid", u_if.dp_rsp_valid, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Bus write lands in shadow bank 1
        drv(4'hF, 9'h005, 32'hDEADBEEF, 1'b0, 9'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_addr", ram_addr, 10'h205);
        chk("t1_we", ram_we, 4'hF);
        chk("t1_bank", active_bank, 1'b0);

        // Plain read
        drv(4'h0, 9'h0, 32'h0, 1'b1, 9'h010, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_ready", u_if.dp_req_ready, 1'b1);
        chk("t2_addr", ram_addr, 10'h010);
        idle();
        @(negedge clk);
        chk("t2_rsp_valid", u_if.dp_rsp_valid, 1'b1);
        chk("t2_rsp_data", u_if.dp_rsp_data, 32'hC0DE0010);

        // Write beats read, read retried next cycle
        drv(4'hF, 9'h010, 32'h12345678, 1'b1, 9'h011, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_ready", u_if.dp_req_ready, 1'b0);
        chk("t3_addr", ram_addr, 10'h210);
        drv(4'h0, 9'h0, 32'h0, 1'b1, 9'h011, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_ready2", u_if.dp_req_ready, 1'b1);
        chk("t3_rsp_gap", u_if.dp_rsp_valid, 1'b0);
        idle();
        @(negedge clk);
        chk("t3_rsp_data", u_if.dp_rsp_data, 32'hC0DE0011);

        // Swap at frame boundary
        drv(4'h0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("t4_pending", swap_pending, 1'b1);
        for (int i = 2; i <= 4; i++) drv(4'h0, 9'h0, 32'h0, 1'b1, 9'(i), 1'b0, 1'b0);
        drv(4'h0, 9'h0, 32'h0, 1'b1, 9'h001, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_fe_addr", ram_addr, 10'h001);
        drv(4'h0, 9'h0, 32'h0, 1'b1, 9'h005, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_new_addr", ram_addr, 10'h205);
        chk("t4_bank", active_bank, 1'b1);
        chk("t4_pending0", swap_pending, 1'b0);
        chk("t4_rsp_old", u_if.dp_rsp_data, 32'hC0DE0001);
        idle();
        @(negedge clk);
        chk("t4_rsp_new", u_if.dp_rsp_data, 32'hDEADBEEF);

        // swap_req with frame_end in RUN only arms
        drv(4'h0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("t5_pending", swap_pending, 1'b1);
        chk("t5_bank", active_bank, 1'b1);
        drv(4'h0, 9'h0, 32'h0, 1'b0, 9'h0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("t5_bank_swapped", active_bank, 1'b0);

        // Starvation
        for (int k = 1; k <= 16; k++) begin
            drv(4'hF, 9'(k), 32'(k), 1'b1, 9'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 16) chk("t6_err_before", stall_err, 1'b0);
        end
        idle();
        @(negedge clk);
        chk("t6_err_set", stall_err, 1'b1);
        repeat (3) idle();
        @(negedge clk);
        chk("t6_err_sticky", stall_err, 1'b1);

        // Randomized traffic with one mid-run reset dropping an in-flight response
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                drv(4'h0, 9'h0, 32'h0, 1'b1, 9'h033, 1'b0, 1'b0);
                idle();
                rst_n = 1'b0;
                @(negedge clk);
                chk("rnd_rst_rsp", u_if.dp_rsp_valid, 1'b0);
                chk("rnd_rst_err", stall_err, 1'b0);
                @(posedge clk); #1 rst_n = 1'b1;
            end else begin
                if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(10, 22);
                if (burst > 0) begin
                    burst--;
                    drv(4'hF, 9'($urandom), $urandom, 1'b1, 9'($urandom), 1'b0, 1'b0);
                end else begin
                    drv(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                        9'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 3) != 0, 9'($urandom_range(0, 15)),
                        $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
                end
            end
        end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
